// File: rtl/rheed_result_packer.sv
// rheed_result_packer: stamps each 110-bit RHEED CNN result (five 22-bit lanes)
// with a frame number and 64-bit timestamp, buffers it in a DEPTH-word FIFO and
// streams 256-bit words out in BATCH-word packets (tlast closes each packet).
// The input side never stalls: results arriving on a full FIFO are dropped and
// counted. A flush pulse closes a partial packet, using a "FLUS" filler word
// when there is no buffered data left to carry the tlast.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   enable               0: input results are ignored and not counted
//   flush                single-cycle pulse closing the current partial packet
//   s_axis_*             CNN result stream (tready is 1 whenever out of reset)
//   m_axis_*             packed 256-bit output stream toward the host DMA
//   frame_cnt            results seen while enabled (wraps)
//   drop_cnt             results dropped on a full FIFO (saturates)
//   fifo_level           current FIFO occupancy
module rheed_result_packer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned BATCH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [109:0]               s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [255:0]               m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [31:0]                frame_cnt,
    output logic [31:0]                drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam int unsigned DW = 110;
    localparam int unsigned EW = 32 + 64 + DW;
    localparam logic [31:0] HDR_DATA = 32'h5248_4544;  // "RHED"
    localparam logic [31:0] HDR_FILL = 32'h464C_5553;  // "FLUS"

    typedef enum logic {
        STREAM = 1'b0,
        FILL   = 1'b1
    } state_t;

    state_t            state_q, state_nxt;
    logic              ready_q;
    logic [63:0]       ts_q;
    logic [31:0]       frame_q;
    logic [31:0]       drop_q;
    logic [LW-1:0]     level_q, level_nxt;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]     mem [DEPTH];
    logic [BW-1:0]     bcnt_q, bcnt_nxt;
    logic              pend_q, pend_nxt;
    logic              stall_q, last_q;
    logic [31:0]       fill_frame_q;
    logic [63:0]       fill_ts_q;

    logic              accept, full, empty, wr_en, rd_en, drop;
    logic              hs, last_hs, live_last;
    logic [EW-1:0]     rd_entry;

    // Next-state decode and output word selection
    always_comb begin
        state_nxt     = state_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        live_last     = 1'b0;
        rd_entry      = mem[rd_ptr_q];

        accept = s_axis_tvalid & ready_q & enable;
        full   = (level_q == LW'(DEPTH));
        empty  = (level_q == '0);
        wr_en  = accept & ~full;
        drop   = accept & full;

        case (state_q)
            STREAM: begin
                m_axis_tvalid = ~empty;
                live_last     = (bcnt_q == BW'(BATCH - 1)) |
                                (pend_q & (level_q == LW'(1)));
                if (!empty) begin
                    m_axis_tdata = {HDR_DATA, rd_entry[EW-1 -: 32],
                                    rd_entry[DW+63 -: 64], 18'd0, rd_entry[DW-1:0]};
                end
            end
            FILL: begin
                m_axis_tvalid = 1'b1;
                live_last     = 1'b1;
                m_axis_tdata  = {HDR_FILL, fill_frame_q, fill_ts_q, 128'd0};
            end
            default: state_nxt = STREAM;
        endcase

        // Once a word has been stalled its tlast is frozen, so a later write
        // or flush cannot change it mid-handshake.
        m_axis_tlast = m_axis_tvalid & (stall_q ? last_q : live_last);

        hs      = m_axis_tvalid & m_axis_tready;
        last_hs = hs & m_axis_tlast;
        rd_en   = hs & (state_q == STREAM);

        level_nxt = level_q + LW'(wr_en) - LW'(rd_en);

        bcnt_nxt = bcnt_q;
        if (last_hs) begin
            bcnt_nxt = '0;
        end else if (hs) begin
            bcnt_nxt = (bcnt_q == BW'(BATCH - 1)) ? '0 : bcnt_q + BW'(1);
        end

        // A flush with nothing open (no words sent, none buffered) is ignored
        if (last_hs) begin
            pend_nxt = 1'b0;
        end else begin
            pend_nxt = pend_q | (flush & ~((bcnt_q == '0) & empty));
        end

        if (state_q == STREAM) begin
            if (pend_q && empty && (bcnt_q != '0)) begin
                state_nxt = FILL;
            end
        end else if (hs) begin
            state_nxt = STREAM;
        end
    end

    // State, counters and FIFO control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= STREAM;
            ready_q      <= 1'b0;
            ts_q         <= '0;
            frame_q      <= '0;
            drop_q       <= '0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            bcnt_q       <= '0;
            pend_q       <= 1'b0;
            stall_q      <= 1'b0;
            last_q       <= 1'b0;
            fill_frame_q <= '0;
            fill_ts_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            ready_q  <= 1'b1;
            ts_q     <= ts_q + 64'd1;
            level_q  <= level_nxt;
            bcnt_q   <= bcnt_nxt;
            pend_q   <= pend_nxt;
            stall_q  <= m_axis_tvalid & ~m_axis_tready;
            last_q   <= m_axis_tlast;
            if (accept) begin
                frame_q <= frame_q + 32'd1;
            end
            if (drop && (drop_q != 32'hFFFF_FFFF)) begin
                drop_q <= drop_q + 32'd1;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Filler carries the frame count and timestamp of its first
            // presentation cycle, then holds them until handshaken.
            if ((state_q == STREAM) && (state_nxt == FILL)) begin
                fill_frame_q <= frame_q + 32'(accept);
                fill_ts_q    <= ts_q + 64'd1;
            end
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {frame_q, ts_q, s_axis_tdata};
        end
    end

    assign s_axis_tready = ready_q;
    assign frame_cnt     = frame_q;
    assign drop_cnt      = drop_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_rheed_result_packer.sv
// Directed bench for rheed_result_packer: expected words are queued when
// stimulus is driven and compared as the DUT hands them off downstream.
module tb_rheed_result_packer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned BATCH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          flush = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [109:0]  s_axis_tdata = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [255:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic [31:0]   frame_cnt;
    logic [31:0]   drop_cnt;
    logic [$clog2(DEPTH):0] fifo_level;

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] tb_ts = '0;
    logic [31:0] mframe = '0;

    rheed_result_packer #(.DEPTH(DEPTH), .BATCH(BATCH)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .flush         (flush),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 64'd1;
    end

    function automatic logic [109:0] mkd(input int i);
        return {22'(i + 100), 22'h2AAAA, 22'h15555, 22'(i * 7), 22'(i)};
    endfunction

    function automatic logic [255:0] mkw(input logic [31:0] fr, input logic [63:0] ts,
                                         input logic [109:0] d);
        return {32'h5248_4544, fr, ts, 18'd0, d};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check any handshake at the falling edge, return #1 after rise
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word observed=%0h expected=none", m_axis_tdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tdata", m_axis_tdata, e.data);
                chk("tlast", 256'(m_axis_tlast), 256'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [109:0] d, input bit store, input bit last, input bit counted);
        exp_t e;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        if (store) begin
            e.data = mkw(mframe, tb_ts, d);
            e.last = last;
            sb.push_back(e);
        end
        if (counted) mframe++;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick();
        chk("drain_empty", 256'(sb.size()), 256'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        mframe = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        exp_t h;
        exp_t f;

        // Reset state
        tick();
        chk("rst_s_tready", 256'(s_axis_tready), 256'd0);
        chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("rst_m_tdata", m_axis_tdata, 256'd0);
        chk("rst_m_tlast", 256'(m_axis_tlast), 256'd0);
        chk("rst_frame_cnt", 256'(frame_cnt), 256'd0);
        chk("rst_drop_cnt", 256'(drop_cnt), 256'd0);
        chk("rst_fifo_level", 256'(fifo_level), 256'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_release", 256'(s_axis_tready), 256'd1);
        tick();

        // 1: one full batch with tready high
        m_axis_tready = 1'b1;
        chk("t1_idle_valid", 256'(m_axis_tvalid), 256'd0);
        send(mkd(1), 1'b1, 1'b0, 1'b1);
        chk("t1_first_valid", 256'(m_axis_tvalid), 256'd1);
        for (int i = 2; i <= 8; i++) send(mkd(i), 1'b1, i == 8, 1'b1);
        drain(20);

        // 2: overflow while stalled, then drain in two packets
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) send(mkd(i + 1), i < 16, (i % 8) == 7, 1'b1);
        chk("t2_level", 256'(fifo_level), 256'd16);
        chk("t2_drop_cnt", 256'(drop_cnt), 256'd4);
        chk("t2_frame_cnt", 256'(frame_cnt), 256'd20);
        chk("t2_s_tready", 256'(s_axis_tready), 256'd1);
        m_axis_tready = 1'b1;
        drain(40);

        // 3: flush with data buffered closes on the last buffered word
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(mkd(30 + i), 1'b1, i == 2, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_first_no_last", 256'(m_axis_tlast), 256'd0);
        m_axis_tready = 1'b1;
        drain(20);
        for (int i = 0; i < 8; i++) send(mkd(40 + i), 1'b1, i == 7, 1'b1);
        drain(20);

        // 4: flush with empty FIFO emits a filler; result during FILL follows it
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) send(mkd(60 + i), 1'b1, 1'b0, 1'b1);
        drain(20);
        f.data = {32'h464C_5553, mframe, tb_ts + 64'd2, 128'd0};
        f.last = 1'b1;
        sb.push_back(f);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t4_fill_valid", 256'(m_axis_tvalid), 256'd1);
        send(mkd(70), 1'b1, 1'b0, 1'b1);
        drain(20);

        // 5: stall on a tlast word while another result arrives
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 7; i++) send(mkd(80 + i), 1'b1, 1'b0, 1'b1);
        drain(20);
        m_axis_tready = 1'b0;
        send(mkd(87), 1'b1, 1'b1, 1'b1);
        h = sb[0];
        for (int k = 0; k < 5; k++) begin
            chk("t5_stall_tdata", m_axis_tdata, h.data);
            chk("t5_stall_tlast", 256'(m_axis_tlast), 256'd1);
            if (k == 0) send(mkd(88), 1'b1, 1'b0, 1'b1);
            else        tick();
        end
        m_axis_tready = 1'b1;
        drain(20);

        // enable low: inputs ignored entirely
        enable = 1'b0;
        for (int i = 0; i < 10; i++) send(mkd(200 + i), 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        chk("t5_en_frame_cnt", 256'(frame_cnt), 256'(mframe));
        chk("t5_en_level", 256'(fifo_level), 256'd0);
        chk("t5_en_valid", 256'(m_axis_tvalid), 256'd0);

        // 6: reset with words buffered discards them; next packet starts fresh
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) send(mkd(90 + i), 1'b1, 1'b0, 1'b1);
        chk("t6_level", 256'(fifo_level), 256'd6);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 256'(m_axis_tvalid), 256'd0);
        chk("t6_rst_tdata", m_axis_tdata, 256'd0);
        chk("t6_rst_tlast", 256'(m_axis_tlast), 256'd0);
        chk("t6_rst_frame", 256'(frame_cnt), 256'd0);
        chk("t6_rst_drop", 256'(drop_cnt), 256'd0);
        chk("t6_rst_level", 256'(fifo_level), 256'd0);
        chk("t6_rst_s_tready", 256'(s_axis_tready), 256'd0);
        sb.delete();
        mframe = '0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) send(mkd(100 + i), 1'b1, i == 7, 1'b1);
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
